l2_flush_engine: RTL and testbench

//  Sweeps every set of one L2 way on flush_req. For each valid+dirty line it reads tag/data

---
 rtl/l2_flush_engine.sv | 118 +++++++++++
 tb/tb_l2_flush_engine.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_flush_engine.sv
// L2 flush engine: sweeps one way and writes dirty lines back to pmem.
// Clears each dirty bit after its write-back completes.
module l2_flush_engine #(
  parameter int s_index  = 3,
  parameter int s_offset = 5,
  parameter int s_tag    = 24,
  parameter int width    = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_req,
  output logic               busy,
  output logic               flush_done,
  output logic               arr_read,
  output logic [s_index-1:0] arr_rindex,
  input  logic               valid_in,
  input  logic               dirty_in,
  input  logic [s_tag-1:0]   tag_in,
  input  logic [width-1:0]   data_in,
  output logic               dirty_load,
  output logic [s_index-1:0] dirty_windex,
  output logic               dirty_datain,
  output logic               pmem_write,
  output logic [31:0]        pmem_address,
  output logic [width-1:0]   pmem_wdata,
  input  logic               pmem_resp
);

  localparam logic [s_index-1:0] last = '1;

  typedef enum logic [2:0] {
    IDLE, CHECK, WRITE, CLEAR, DONE
  } state_t;

  state_t             state;
  logic [s_index-1:0] idx;
  logic [s_tag-1:0]   tag_q;
  logic [width-1:0]   data_q;

  assign arr_rindex   = idx;
  assign dirty_windex = idx;
  assign dirty_datain = 1'b0;
  assign pmem_address = {tag_q, idx, {s_offset{1'b0}}};
  assign pmem_wdata   = data_q;

  // Strobes are registered alongside the state so no input reaches an output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      tag_q      <= '0;
      data_q     <= '0;
      busy       <= 1'b0;
      flush_done <= 1'b0;
      arr_read   <= 1'b0;
      dirty_load <= 1'b0;
      pmem_write <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (flush_req) begin
            state    <= CHECK;
            idx      <= '0;
            busy     <= 1'b1;
            arr_read <= 1'b1;
          end
        end
        CHECK: begin
          if (valid_in && dirty_in) begin
            state      <= WRITE;
            tag_q      <= tag_in;
            data_q     <= data_in;
            arr_read   <= 1'b0;
            pmem_write <= 1'b1;
          end else if (idx == last) begin
            state      <= DONE;
            arr_read   <= 1'b0;
            flush_done <= 1'b1;
          end else begin
            idx <= idx + s_index'(1);
          end
        end
        WRITE: begin
          if (pmem_resp) begin
            state      <= CLEAR;
            pmem_write <= 1'b0;
            dirty_load <= 1'b1;
          end
        end
        CLEAR: begin
          dirty_load <= 1'b0;
          if (idx == last) begin
            state      <= DONE;
            flush_done <= 1'b1;
          end else begin
            state    <= CHECK;
            idx      <= idx + s_index'(1);
            arr_read <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          flush_done <= 1'b0;
          busy       <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          flush_done <= 1'b0;
          arr_read   <= 1'b0;
          dirty_load <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_flush_engine.sv
// Directed bench for l2_flush_engine with way-array model,
// pmem responder and write-back scoreboard.
module tb_l2_flush_engine;

  logic         clk;
  logic         rst_n;
  logic         flush_req;
  logic         busy;
  logic         flush_done;
  logic         arr_read;
  logic [2:0]   arr_rindex;
  logic         valid_in;
  logic         dirty_in;
  logic [23:0]  tag_in;
  logic [255:0] data_in;
  logic         dirty_load;
  logic [2:0]   dirty_windex;
  logic         dirty_datain;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;

  l2_flush_engine dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_req    (flush_req),
    .busy         (busy),
    .flush_done   (flush_done),
    .arr_read     (arr_read),
    .arr_rindex   (arr_rindex),
    .valid_in     (valid_in),
    .dirty_in     (dirty_in),
    .tag_in       (tag_in),
    .data_in      (data_in),
    .dirty_load   (dirty_load),
    .dirty_windex (dirty_windex),
    .dirty_datain (dirty_datain),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  addr;
    logic [255:0] data;
  } wr_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // way-array model
  logic         valid_m [8];
  logic [23:0]  tag_m   [8];
  logic [255:0] data_m  [8];
  logic [7:0]   dirty_m;
  logic [7:0]   dirty_cfg;
  logic         load_cfg;

  assign valid_in = arr_read ? valid_m[arr_rindex] : 1'b0;
  assign dirty_in = arr_read ? dirty_m[arr_rindex] : 1'b0;
  assign tag_in   = arr_read ? tag_m[arr_rindex] : 24'h0;
  assign data_in  = arr_read ? data_m[arr_rindex] : 256'h0;

  always @(posedge clk) begin
    if (load_cfg) dirty_m <= dirty_cfg;
    else if (dirty_load) dirty_m[dirty_windex] <= dirty_datain;
  end

  // pmem responder
  int   resp_delay;
  int   wcnt = 0;
  logic resp_auto = 1'b0;
  logic resp_force;

  assign pmem_resp = resp_auto | resp_force;

  always @(negedge clk) begin
    if (pmem_write) begin
      wcnt++;
      resp_auto = (wcnt == resp_delay);
    end else begin
      wcnt = 0;
      resp_auto = 1'b0;
    end
  end

  // scoreboard / monitor
  wr_t          exp_q [$];
  logic [2:0]   dl_q  [$];
  logic [2:0]   idxq  [$];
  int           fd_cnt = 0;
  int           wr_cnt = 0;
  int           wlen = 0;
  int           last_wlen = 0;
  logic         pw_prev = 1'b0;
  logic [31:0]  cur_addr;
  logic [255:0] cur_data;

  always @(negedge clk) begin
    if (pmem_write && !pw_prev) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", {224'h0, pmem_address}, 256'h0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {224'h0, pmem_address}, {224'h0, e.addr});
        chk("wr_data", pmem_wdata, e.data);
      end
      cur_addr = pmem_address;
      cur_data = pmem_wdata;
      wlen = 1;
    end else if (pmem_write) begin
      wlen++;
      chk("wr_addr_stable", {224'h0, pmem_address}, {224'h0, cur_addr});
      chk("wr_data_stable", pmem_wdata, cur_data);
    end
    if (!pmem_write && pw_prev) last_wlen = wlen;
    if (dirty_load) begin
      dl_q.push_back(dirty_windex);
      chk("dirty_datain", {255'h0, dirty_datain}, 256'h0);
    end
    if (flush_done) fd_cnt++;
    pw_prev = pmem_write;
  end

  task automatic setup(input logic [7:0] v, input logic [7:0] d);
    for (int i = 0; i < 8; i++) valid_m[i] = v[i];
    dirty_cfg = d;
    load_cfg = 1'b1;
    @(negedge clk);
    load_cfg = 1'b0;
    exp_q.delete();
    dl_q.delete();
  endtask

  task automatic push_wr(input int s);
    wr_t e;
    e.addr = {tag_m[s], 3'(s), 5'b0};
    e.data = data_m[s];
    exp_q.push_back(e);
  endtask

  // Pulse flush_req, then follow the sweep counting cycles after edge 0.
  task automatic sweep(input int req_at, input int resp_at,
                       output int done_at);
    int n;
    done_at = -1;
    idxq.delete();
    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    n = 1;
    forever begin
      if (arr_read) idxq.push_back(arr_rindex);
      if (flush_done) begin
        done_at = n;
        break;
      end
      if (n >= 200) break;
      flush_req  = (n == req_at);
      resp_force = (n == resp_at);
      @(negedge clk);
      n++;
    end
    flush_req  = 1'b0;
    resp_force = 1'b0;
  endtask

  task automatic after_done(input string t, input int fd0);
    @(negedge clk);
    chk({t, "_busy_off"}, {255'h0, busy}, 256'h0);
    chk({t, "_done_pulse"}, {255'h0, flush_done}, 256'h0);
    chk({t, "_done_cnt"}, 256'(fd_cnt - fd0), 256'd1);
    chk({t, "_q_empty"}, 256'(exp_q.size()), 256'd0);
  endtask

  int done_at;
  int fd0;
  int wr0;
  int n;

  initial begin
    rst_n = 1'b0;
    flush_req = 1'b0;
    resp_force = 1'b0;
    load_cfg = 1'b0;
    dirty_cfg = 8'h00;
    resp_delay = 1;
    for (int i = 0; i < 8; i++) begin
      valid_m[i] = 1'b0;
      tag_m[i] = 24'h100000 + 24'(i);
      data_m[i] = {8{$urandom()}};
    end
    #2;
    chk("rst_busy", {255'h0, busy}, 256'h0);
    chk("rst_pmem_write", {255'h0, pmem_write}, 256'h0);
    chk("rst_arr_read", {255'h0, arr_read}, 256'h0);
    chk("rst_dirty_load", {255'h0, dirty_load}, 256'h0);
    chk("rst_done", {255'h0, flush_done}, 256'h0);
    chk("rst_addr", {224'h0, pmem_address}, 256'h0);
    chk("rst_wdata", pmem_wdata, 256'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: all clean
    setup(8'hFF, 8'h00);
    fd0 = fd_cnt;
    wr0 = wr_cnt;
    sweep(-1, -1, done_at);
    chk("t1_done_at", 256'(done_at), 256'd9);
    chk("t1_idx_cnt", 256'(idxq.size()), 256'd8);
    for (int i = 0; i < 8 && i < idxq.size(); i++)
      chk("t1_idx_step", {253'h0, idxq[i]}, 256'(i));
    chk("t1_no_write", 256'(wr_cnt - wr0), 256'd0);
    after_done("t1", fd0);

    // 2: set 3 dirty, response after 4 cycles
    tag_m[3] = 24'hABCDEF;
    data_m[3] = {32{8'h5A}};
    resp_delay = 4;
    setup(8'hFF, 8'h08);
    push_wr(3);
    chk("t2_exp_addr", {224'h0, exp_q[0].addr}, {224'h0, 32'hABCDEF60});
    fd0 = fd_cnt;
    sweep(-1, -1, done_at);
    chk("t2_done_at", 256'(done_at), 256'd14);
    chk("t2_wlen", 256'(last_wlen), 256'd4);
    chk("t2_dl_cnt", 256'(dl_q.size()), 256'd1);
    if (dl_q.size() > 0) chk("t2_dl_idx", {253'h0, dl_q[0]}, 256'd3);
    chk("t2_dirty_clr", {248'h0, dirty_m}, 256'h0);
    after_done("t2", fd0);

    // 3: sets 0 and 7 dirty, immediate response
    tag_m[0] = 24'h123456;
    tag_m[7] = 24'h654321;
    data_m[0] = {8{32'h0000_1111}};
    data_m[7] = {8{32'hFEDC_BA98}};
    resp_delay = 1;
    setup(8'hFF, 8'h81);
    push_wr(0);
    push_wr(7);
    fd0 = fd_cnt;
    wr0 = wr_cnt;
    sweep(-1, -1, done_at);
    chk("t3_done_at", 256'(done_at), 256'd13);
    chk("t3_writes", 256'(wr_cnt - wr0), 256'd2);
    chk("t3_idx_cnt", 256'(idxq.size()), 256'd8);
    chk("t3_dl_cnt", 256'(dl_q.size()), 256'd2);
    if (dl_q.size() > 1) begin
      chk("t3_dl_0", {253'h0, dl_q[0]}, 256'd0);
      chk("t3_dl_1", {253'h0, dl_q[1]}, 256'd7);
    end
    after_done("t3", fd0);

    // 4: set 2 dirty but invalid
    setup(8'hFB, 8'h04);
    fd0 = fd_cnt;
    wr0 = wr_cnt;
    sweep(-1, -1, done_at);
    chk("t4_done_at", 256'(done_at), 256'd9);
    chk("t4_no_write", 256'(wr_cnt - wr0), 256'd0);
    chk("t4_no_clear", 256'(dl_q.size()), 256'd0);
    chk("t4_dirty_kept", {255'h0, dirty_m[2]}, 256'd1);
    after_done("t4", fd0);

    // 5: reset during the write of set 5
    tag_m[5] = 24'h0F0F0F;
    data_m[5] = {4{64'hC0FFEE00_12345678}};
    resp_delay = 1000;
    setup(8'hFF, 8'h20);
    push_wr(5);
    fd0 = fd_cnt;
    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    n = 0;
    while (!pmem_write && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t5_in_write", {255'h0, pmem_write}, 256'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_pmem_write", {255'h0, pmem_write}, 256'h0);
    chk("t5_busy", {255'h0, busy}, 256'h0);
    chk("t5_arr_read", {255'h0, arr_read}, 256'h0);
    chk("t5_dirty_load", {255'h0, dirty_load}, 256'h0);
    chk("t5_addr", {224'h0, pmem_address}, 256'h0);
    chk("t5_wdata", pmem_wdata, 256'h0);
    chk("t5_rindex", {253'h0, arr_rindex}, 256'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    resp_delay = 1;
    chk("t5_no_done", 256'(fd_cnt - fd0), 256'd0);
    chk("t5_no_clear", 256'(dl_q.size()), 256'd0);
    chk("t5_dirty_kept", {255'h0, dirty_m[5]}, 256'd1);
    push_wr(5);
    sweep(-1, -1, done_at);
    chk("t5_done_at", 256'(done_at), 256'd11);
    if (idxq.size() > 0) chk("t5_restart_idx", {253'h0, idxq[0]}, 256'd0);
    chk("t5_dl_cnt", 256'(dl_q.size()), 256'd1);
    after_done("t5", fd0);

    // 6: stray flush_req and pmem_resp while sweeping
    setup(8'hFF, 8'h00);
    fd0 = fd_cnt;
    wr0 = wr_cnt;
    sweep(4, 3, done_at);
    chk("t6_done_at", 256'(done_at), 256'd9);
    for (int i = 0; i < 12; i++) @(negedge clk);
    chk("t6_one_done", 256'(fd_cnt - fd0), 256'd1);
    chk("t6_idle", {255'h0, busy}, 256'h0);
    chk("t6_no_write", 256'(wr_cnt - wr0), 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
